// File: rtl/adc_spi_responder.sv
// Responder model of an 8-channel 12-bit serial ADC: samples a 3-bit channel
// address from ADC_SADDR and returns 4 zeros plus a 12-bit sample on ADC_SDAT.
module adc_spi_responder #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic        sys_clk,
  input  logic        reset_n,
  input  logic        ADC_CS_N,
  input  logic        ADC_SCLK,
  input  logic        ADC_SADDR,
  output logic        ADC_SDAT,
  input  logic [95:0] ch_data,
  output logic [2:0]  cur_channel,
  output logic        frame_done,
  output logic [15:0] frame_count
);

  typedef enum logic [1:0] {WAIT_IDLE, IDLE, ACTIVE, DONE} state_t;

  logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
  logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
  logic [SYNC_STAGES-1:0] saddr_sync_q, saddr_sync_d;
  logic [SYNC_STAGES-1:0] primed_q, primed_d;
  logic                   cs_last_q, cs_last_d;
  logic                   sclk_last_q, sclk_last_d;

  state_t      state_q, state_d;
  logic [4:0]  rise_cnt_q, rise_cnt_d;
  logic [2:0]  addr_next_q, addr_next_d;
  logic [15:0] shift_q, shift_d;
  logic        sdat_q, sdat_d;
  logic [2:0]  cur_channel_q, cur_channel_d;
  logic        frame_done_q, frame_done_d;
  logic [15:0] frame_count_q, frame_count_d;

  logic        cs, sclk, saddr;
  logic        cs_rise, cs_fall, sclk_rise, sclk_fall;
  logic [4:0]  rise_inc;
  logic [11:0] sample;

  always_comb begin
    cs_sync_d    = {cs_sync_q[SYNC_STAGES-2:0], ADC_CS_N};
    sclk_sync_d  = {sclk_sync_q[SYNC_STAGES-2:0], ADC_SCLK};
    saddr_sync_d = {saddr_sync_q[SYNC_STAGES-2:0], ADC_SADDR};
    // primed_q tracks which sync stages hold a pin sample taken after reset,
    // so the preset 1 on CS_N cannot be mistaken for an idle bus.
    primed_d     = {primed_q[SYNC_STAGES-2:0], 1'b1};
    cs           = cs_sync_q[SYNC_STAGES-1];
    sclk         = sclk_sync_q[SYNC_STAGES-1];
    saddr        = saddr_sync_q[SYNC_STAGES-1];
    cs_last_d    = cs;
    sclk_last_d  = sclk;
    cs_rise      = cs & ~cs_last_q;
    cs_fall      = ~cs & cs_last_q;
    sclk_rise    = sclk & ~sclk_last_q;
    sclk_fall    = ~sclk & sclk_last_q;
  end

  always_comb begin
    sample = '0;
    case (cur_channel_q)
      3'd0: sample = ch_data[11:0];
      3'd1: sample = ch_data[23:12];
      3'd2: sample = ch_data[35:24];
      3'd3: sample = ch_data[47:36];
      3'd4: sample = ch_data[59:48];
      3'd5: sample = ch_data[71:60];
      3'd6: sample = ch_data[83:72];
      3'd7: sample = ch_data[95:84];
      default: sample = '0;
    endcase
  end

  always_comb begin
    state_d       = state_q;
    rise_cnt_d    = rise_cnt_q;
    addr_next_d   = addr_next_q;
    shift_d       = shift_q;
    sdat_d        = sdat_q;
    cur_channel_d = cur_channel_q;
    frame_done_d  = 1'b0;
    frame_count_d = frame_count_q;
    rise_inc      = (rise_cnt_q == 5'd16) ? 5'd16 : rise_cnt_q + 5'd1;

    case (state_q)
      WAIT_IDLE: begin
        sdat_d = 1'b0;
        if (cs && primed_q[SYNC_STAGES-1]) state_d = IDLE;
      end
      IDLE: begin
        sdat_d     = 1'b0;
        rise_cnt_d = '0;
        if (cs_fall) begin
          shift_d = {4'b0000, sample};
          sdat_d  = 1'b0;
          state_d = ACTIVE;
        end
      end
      ACTIVE: begin
        if (sclk_rise) begin
          rise_cnt_d = rise_inc;
          case (rise_inc)
            5'd3: addr_next_d[2] = saddr;
            5'd4: addr_next_d[1] = saddr;
            5'd5: addr_next_d[0] = saddr;
            default: ;
          endcase
        end
        if (sclk_fall && rise_cnt_q >= 5'd1 && rise_cnt_q <= 5'd15) begin
          shift_d = {shift_q[14:0], 1'b0};
          sdat_d  = shift_q[14];
        end
        // Completion wins over a coincident CS_N rise; only the next state differs.
        if (sclk_rise && rise_inc == 5'd16) begin
          cur_channel_d = addr_next_q;
          frame_done_d  = 1'b1;
          frame_count_d = frame_count_q + 16'd1;
          sdat_d        = 1'b0;
          state_d       = cs_rise ? IDLE : DONE;
        end else if (cs_rise) begin
          sdat_d  = 1'b0;
          state_d = IDLE;
        end
      end
      DONE: begin
        sdat_d = 1'b0;
        if (cs_rise) state_d = IDLE;
      end
      default: state_d = WAIT_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      cs_sync_q     <= '1;
      sclk_sync_q   <= '1;
      saddr_sync_q  <= '0;
      primed_q      <= '0;
      cs_last_q     <= 1'b1;
      sclk_last_q   <= 1'b1;
      state_q       <= WAIT_IDLE;
      rise_cnt_q    <= '0;
      addr_next_q   <= '0;
      shift_q       <= '0;
      sdat_q        <= 1'b0;
      cur_channel_q <= '0;
      frame_done_q  <= 1'b0;
      frame_count_q <= '0;
    end else begin
      cs_sync_q     <= cs_sync_d;
      sclk_sync_q   <= sclk_sync_d;
      saddr_sync_q  <= saddr_sync_d;
      primed_q      <= primed_d;
      cs_last_q     <= cs_last_d;
      sclk_last_q   <= sclk_last_d;
      state_q       <= state_d;
      rise_cnt_q    <= rise_cnt_d;
      addr_next_q   <= addr_next_d;
      shift_q       <= shift_d;
      sdat_q        <= sdat_d;
      cur_channel_q <= cur_channel_d;
      frame_done_q  <= frame_done_d;
      frame_count_q <= frame_count_d;
    end
  end

  assign ADC_SDAT    = sdat_q;
  assign cur_channel = cur_channel_q;
  assign frame_done  = frame_done_q;
  assign frame_count = frame_count_q;

endmodule

// File: tb/tb_adc_spi_responder.sv
// Bench for adc_spi_responder: acts as the SPI initiator and checks returned
// samples, channel pipelining, abort, extra clocks, count wrap and reset.
module tb_adc_spi_responder;

  localparam int unsigned SS   = 2;
  localparam int          HALF = 6;

  logic        sys_clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        cs_n    = 1'b1;
  logic        sclk    = 1'b1;
  logic        saddr   = 1'b0;
  logic        sdat;
  logic [95:0] ch_data;
  logic [2:0]  cur_channel;
  logic        frame_done;
  logic [15:0] frame_count;

  int total = 0;
  int bad   = 0;
  int done_cnt = 0;
  int sdat_hi  = 0;

  typedef struct {
    logic [2:0]  addr;
    logic [15:0] exp_rx;
    logic [2:0]  exp_ch;
    logic [15:0] exp_cnt;
  } vec_t;

  vec_t vt [10];

  adc_spi_responder #(.SYNC_STAGES(SS)) dut (
    .sys_clk    (sys_clk),
    .reset_n    (reset_n),
    .ADC_CS_N   (cs_n),
    .ADC_SCLK   (sclk),
    .ADC_SADDR  (saddr),
    .ADC_SDAT   (sdat),
    .ch_data    (ch_data),
    .cur_channel(cur_channel),
    .frame_done (frame_done),
    .frame_count(frame_count)
  );

  always #5 sys_clk = ~sys_clk;

  always @(negedge sys_clk) begin
    if (frame_done) done_cnt++;
    if (sdat) sdat_hi++;
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge sys_clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Initiator frame: rx holds bits sampled on rises 1..16, extra_hi counts
  // ones seen on rises beyond 16; abort_at>0 raises CS_N after that rise.
  task automatic run_frame(input logic [2:0] addr, input int nclk, input int abort_at,
                           output logic [15:0] rx, output int extra_hi);
    rx = '0;
    extra_hi = 0;
    cs_n = 1'b0;
    cyc(HALF);
    for (int i = 1; i <= nclk; i++) begin
      sclk  = 1'b0;
      saddr = (i == 3) ? addr[2] : (i == 4) ? addr[1] : (i == 5) ? addr[0] : 1'b0;
      cyc(HALF);
      if (i <= 16) rx = {rx[14:0], sdat};
      else if (sdat) extra_hi++;
      sclk = 1'b1;
      if (abort_at == i) begin
        cyc(HALF);
        cs_n = 1'b1;
        return;
      end
      cyc(HALF);
    end
    cyc(HALF);
    cs_n = 1'b1;
    cyc(2 * HALF);
  endtask

  initial begin
    logic [15:0] rx;
    int xh, d0, h0;

    ch_data = {12'h6E9, 12'hFFF, 12'h001, 12'h800, 12'h123, 12'hF0F, 12'h3B7, 12'hA5C};
    vt[0] = '{3'd0, 16'h0A5C, 3'd0, 16'd1};
    vt[1] = '{3'd3, 16'h0A5C, 3'd3, 16'd2};
    vt[2] = '{3'd7, 16'h0123, 3'd7, 16'd3};
    vt[3] = '{3'd5, 16'h06E9, 3'd5, 16'd4};
    vt[4] = '{3'd1, 16'h0001, 3'd1, 16'd5};
    vt[5] = '{3'd6, 16'h03B7, 3'd6, 16'd6};
    vt[6] = '{3'd4, 16'h0FFF, 3'd4, 16'd7};
    vt[7] = '{3'd2, 16'h0800, 3'd2, 16'd8};
    vt[8] = '{3'd0, 16'h0F0F, 3'd0, 16'd9};
    vt[9] = '{3'd6, 16'h0A5C, 3'd6, 16'd10};

    reset_n = 1'b0;
    cyc(3);
    chk("rst_sdat", 32'(sdat), 0);
    chk("rst_ch", 32'(cur_channel), 0);
    chk("rst_cnt", 32'(frame_count), 0);
    chk("rst_done", 32'(frame_done), 0);
    reset_n = 1'b1;
    cyc(5);
    chk("idle_no_done", 32'(done_cnt), 0);

    for (int i = 0; i < 10; i++) begin
      d0 = done_cnt;
      run_frame(vt[i].addr, 16, 0, rx, xh);
      chk($sformatf("vec%0d_rx", i), 32'(rx), 32'(vt[i].exp_rx));
      chk($sformatf("vec%0d_pulses", i), 32'(done_cnt - d0), 1);
      chk($sformatf("vec%0d_ch", i), 32'(cur_channel), 32'(vt[i].exp_ch));
      chk($sformatf("vec%0d_cnt", i), 32'(frame_count), 32'(vt[i].exp_cnt));
    end

    // Abort after 9 rises while channel 6 (0xFFF) is selected.
    d0 = done_cnt;
    run_frame(3'd1, 16, 9, rx, xh);
    chk("abort_rx", 32'(rx), 32'h001F);
    cyc(SS);
    chk("abort_hold", 32'(sdat), 1);
    cyc(1);
    chk("abort_sdat", 32'(sdat), 0);
    cyc(2 * HALF);
    chk("abort_pulses", 32'(done_cnt - d0), 0);
    chk("abort_ch", 32'(cur_channel), 6);
    chk("abort_cnt", 32'(frame_count), 10);

    // Recovery frame; ch_data changes mid-frame must not affect it.
    d0 = done_cnt;
    fork
      run_frame(3'd6, 16, 0, rx, xh);
      begin
        cyc(20);
        ch_data[83:72] = 12'h000;
      end
    join
    chk("recov_rx", 32'(rx), 32'h0FFF);
    chk("recov_pulses", 32'(done_cnt - d0), 1);
    chk("recov_ch", 32'(cur_channel), 6);
    chk("recov_cnt", 32'(frame_count), 11);
    ch_data[83:72] = 12'hFFF;

    // 20 SCLK cycles in one frame.
    d0 = done_cnt;
    run_frame(3'd5, 20, 0, rx, xh);
    chk("extra_rx", 32'(rx), 32'h0FFF);
    chk("extra_sdat_hi", 32'(xh), 0);
    chk("extra_pulses", 32'(done_cnt - d0), 1);
    chk("extra_ch", 32'(cur_channel), 5);
    chk("extra_cnt", 32'(frame_count), 12);

    // Count wrap, starting from a preloaded count of 0xFFFE.
    force dut.frame_count_q = 16'hFFFE;
    cyc(1);
    release dut.frame_count_q;
    cyc(2);
    d0 = done_cnt;
    run_frame(3'd5, 16, 0, rx, xh);
    chk("wrap1_rx", 32'(rx), 32'h0001);
    chk("wrap1_cnt", 32'(frame_count), 32'hFFFF);
    run_frame(3'd5, 16, 0, rx, xh);
    chk("wrap2_rx", 32'(rx), 32'h0001);
    chk("wrap2_cnt", 32'(frame_count), 0);
    chk("wrap_pulses", 32'(done_cnt - d0), 2);

    // Reset mid-frame with CS_N held low, then keep clocking.
    cs_n = 1'b0;
    cyc(HALF);
    for (int i = 0; i < 6; i++) begin
      sclk = 1'b0;
      cyc(HALF);
      sclk = 1'b1;
      cyc(HALF);
    end
    reset_n = 1'b0;
    cyc(3);
    reset_n = 1'b1;
    d0 = done_cnt;
    h0 = sdat_hi;
    for (int i = 0; i < 20; i++) begin
      sclk = 1'b0;
      cyc(HALF);
      sclk = 1'b1;
      cyc(HALF);
    end
    chk("midrst_sdat_hi", 32'(sdat_hi - h0), 0);
    chk("midrst_pulses", 32'(done_cnt - d0), 0);
    chk("midrst_ch", 32'(cur_channel), 0);
    chk("midrst_cnt", 32'(frame_count), 0);
    cs_n = 1'b1;
    cyc(2 * HALF);
    d0 = done_cnt;
    run_frame(3'd2, 16, 0, rx, xh);
    chk("postrst_rx", 32'(rx), 32'h0A5C);
    chk("postrst_pulses", 32'(done_cnt - d0), 1);
    chk("postrst_ch", 32'(cur_channel), 2);
    chk("postrst_cnt", 32'(frame_count), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
